// File: rtl/uart_pkg.sv
// Shared definitions for the UART pattern generator.
//   state_e        : FSM state encoding, also driven onto the debug port
//   PAT_*          : run-time pattern select codes
//   DEFAULT_*      : default seed and Galois LFSR feedback mask
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_GAP  = 3'd3
  } state_e;

  localparam logic [1:0] PAT_FIXED = 2'd0;
  localparam logic [1:0] PAT_INC   = 2'd1;
  localparam logic [1:0] PAT_LFSR  = 2'd2;
  localparam logic [1:0] PAT_WALK  = 2'd3;

  localparam logic [31:0] DEFAULT_SEED      = 32'h0000_FFFF;
  localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/uart_pat_src.sv
// Pattern source: holds the current word and the word index of the burst.
//   clk, rst_n  : clock, async active-low reset
//   load_i      : start a new burst (index 0)
//   advance_i   : step to the next word of the burst
//   mode_i      : pattern select (fixed / increment / LFSR / walking one)
//   data_o      : current word, registered
module uart_pat_src
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter logic [31:0] SEED      = DEFAULT_SEED,
  parameter logic [31:0] LFSR_POLY = DEFAULT_LFSR_POLY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] SEED_W = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] POLY_W = DATA_W'(LFSR_POLY);

  logic [DATA_W-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Next word; the index wraps at DATA_W so the walking one rotates.
  always_comb begin
    pat_d = pat_q;
    idx_d = idx_q;
    if (load_i) begin
      idx_d = '0;
      pat_d = (mode_i == PAT_WALK) ? DATA_W'(1) : SEED_W;
    end else if (advance_i) begin
      idx_d = (idx_q == IDX_W'(DATA_W - 1)) ? '0 : idx_q + IDX_W'(1);
      case (mode_i)
        PAT_INC:  pat_d = pat_q + DATA_W'(1);
        PAT_LFSR: pat_d = (pat_q >> 1) ^ (pat_q[0] ? POLY_W : '0);
        PAT_WALK: pat_d = DATA_W'(1) << idx_d;
        default:  pat_d = pat_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      idx_q <= '0;
    end else begin
      pat_q <= pat_d;
      idx_q <= idx_d;
    end
  end

  assign data_o = pat_q;

endmodule

// File: rtl/uart_pattern_gen.sv
// UART stimulus sequencer: sends bursts of NUM_WORDS pattern words over the
// send/send_done handshake, with a programmable gap between words.
//   clk, rst        : clock, async active-low reset
//   start           : begin a burst (sampled in IDLE only)
//   stop            : end after the word in flight
//   mode            : pattern select, latched at burst start
//   continuous      : repeat bursts until stop, latched at burst start
//   send_done       : UART completion
//   send, data      : transfer request and word
//   busy, done      : not-IDLE flag, one-cycle pulse on return to IDLE
//   word_cnt, sta   : words completed in burst, debug state
// Optional macro UART_PATGEN_TIMEOUT_EN adds TIMEOUT_CYCLES and sticky err.
module uart_pattern_gen
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_WORDS  = 8,
  parameter int unsigned GAP_CYCLES = 16,
  parameter logic [31:0] SEED       = DEFAULT_SEED,
  parameter logic [31:0] LFSR_POLY  = DEFAULT_LFSR_POLY
`ifdef UART_PATGEN_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             stop,
  input  logic [1:0]                       mode,
  input  logic                             continuous,
  input  logic                             send_done,
  output logic                             send,
  output logic [DATA_W-1:0]                data,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(NUM_WORDS+1)-1:0]   word_cnt,
`ifdef UART_PATGEN_TIMEOUT_EN
  output logic                             err,
`endif
  output logic [2:0]                       sta
);

  localparam int unsigned CNT_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             cont_q, cont_d;
  logic             stop_q, stop_d;
  logic             send_q, busy_q, done_q, done_d;
  logic             pat_load, pat_adv;
  logic [1:0]       pat_mode;

`ifdef UART_PATGEN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;
`endif

  // The pattern source sees the live mode in LOAD, before mode_q captures it.
  assign pat_mode = (state_q == ST_LOAD) ? mode : mode_q;

  uart_pat_src #(
    .DATA_W    (DATA_W),
    .SEED      (SEED),
    .LFSR_POLY (LFSR_POLY)
  ) u_src (
    .clk       (clk),
    .rst_n     (rst),
    .load_i    (pat_load),
    .advance_i (pat_adv),
    .mode_i    (pat_mode),
    .data_o    (data)
  );

  // Next-state logic: sequencing, gap timing, stop latch, burst wrap.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    cont_d   = cont_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
    pat_load = 1'b0;
    pat_adv  = 1'b0;
`ifdef UART_PATGEN_TIMEOUT_EN
    to_d  = (state_q == ST_SEND) ? to_q : '0;
    err_d = err_q;
`endif
    if (state_q != ST_IDLE && stop) stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        mode_d   = mode;
        cont_d   = continuous;
        cnt_d    = '0;
        stop_d   = 1'b0;
        pat_load = 1'b1;
        state_d  = ST_SEND;
`ifdef UART_PATGEN_TIMEOUT_EN
        err_d = 1'b0;
`endif
      end
      ST_SEND: begin
        if (send_done) begin
          gap_d   = GAP_W'(GAP_CYCLES);
          cnt_d   = cnt_q + CNT_W'(1);
          pat_adv = 1'b1;
          state_d = ST_GAP;
        end
`ifdef UART_PATGEN_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      ST_GAP: begin
        // A zero gap still spends one cycle here so send drops between words.
        if (gap_q > GAP_W'(1)) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (cnt_q != CNT_W'(NUM_WORDS) && !stop_q) begin
          state_d = ST_SEND;
        end else if (!cont_q || stop_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d    = '0;
          pat_load = 1'b1;
          state_d  = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_PATGEN_TIMEOUT_EN
      to_q  <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      send_q  <= (state_d == ST_SEND);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
`ifdef UART_PATGEN_TIMEOUT_EN
      to_q  <= to_d;
      err_q <= err_d;
`endif
    end
  end

  assign send     = send_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign word_cnt = cnt_q;
  assign sta      = state_q;
`ifdef UART_PATGEN_TIMEOUT_EN
  assign err = err_q;
`endif

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Bench for uart_pattern_gen: dut0 uses default parameters with a UART
// responder; dut1 has a zero gap and send_done tied high.
module tb_uart_pattern_gen;

  localparam int unsigned N0   = 8;
  localparam int unsigned GAP0 = 16;
  localparam int unsigned N1   = 4;
  localparam logic [31:0] TB_SEED = 32'h0000FFFF;
  localparam logic [31:0] TB_POLY = 32'h80200003;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        start0, stop0, cont0, sd0, send0, busy0, done0;
  logic [1:0]  mode0;
  logic [31:0] data0;
  logic [3:0]  wc0;
  logic [2:0]  sta0;
  logic        start1, stop1, cont1, sd1, send1, busy1, done1;
  logic [1:0]  mode1;
  logic [31:0] data1;
  logic [2:0]  wc1;
  logic [2:0]  sta1;
`ifdef UART_PATGEN_TIMEOUT_EN
  logic err0, err1;
`endif

  uart_pattern_gen #(
    .DATA_W(32), .NUM_WORDS(N0), .GAP_CYCLES(GAP0)
`ifdef UART_PATGEN_TIMEOUT_EN
    , .TIMEOUT_CYCLES(50)
`endif
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .stop(stop0), .mode(mode0),
    .continuous(cont0), .send_done(sd0), .send(send0), .data(data0),
    .busy(busy0), .done(done0), .word_cnt(wc0),
`ifdef UART_PATGEN_TIMEOUT_EN
    .err(err0),
`endif
    .sta(sta0)
  );

  uart_pattern_gen #(
    .DATA_W(32), .NUM_WORDS(N1), .GAP_CYCLES(0)
  ) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .mode(mode1),
    .continuous(cont1), .send_done(sd1), .send(send1), .data(data1),
    .busy(busy1), .done(done1), .word_cnt(wc1),
`ifdef UART_PATGEN_TIMEOUT_EN
    .err(err1),
`endif
    .sta(sta1)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word i of a burst, straight from the pattern rules.
  function automatic logic [31:0] model_word(input int m, input int i);
    logic [31:0] x;
    x = TB_SEED;
    case (m)
      0: return TB_SEED;
      1: return TB_SEED + 32'(i);
      2: begin
        for (int k = 0; k < i; k++) x = (x >> 1) ^ (x[0] ? TB_POLY : 32'h0);
        return x;
      end
      default: return 32'h1 << (i % 32);
    endcase
  endfunction

  function automatic int model_nwords(input int stop_at);
    return (stop_at > 0) ? stop_at : int'(N0);
  endfunction

  function automatic int model_cnt(input int nw);
    return ((nw - 1) % int'(N0)) + 1;
  endfunction

  // UART responder for dut0: send_done pulses resp_delay cycles into a word.
  int resp_delay = 2;
  int wait_cnt   = 0;
  always @(negedge clk) begin
    if (!rst) begin
      sd0 = 1'b0;
      wait_cnt = 0;
    end else if (sd0) begin
      sd0 = 1'b0;
    end else if (send0) begin
      if (wait_cnt >= resp_delay) begin
        sd0 = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Monitor for dut0: collects words, checks gap length, data hold, done.
  logic [31:0] words_q[$];
  int          done_cnt = 0;
  bit          first_word = 1'b1;
  int          low_run = 0;
  bit          prev_send = 1'b0;
  logic [31:0] held = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_send = 1'b0;
      low_run = 0;
    end else begin
      if (send0 && !prev_send) begin
        words_q.push_back(data0);
        if (!first_word) check("gap_len", 64'(low_run), 64'(GAP0));
        first_word = 1'b0;
      end else if (send0) begin
        check("data_stable", 64'(data0), 64'(held));
      end
      if (done0) begin
        done_cnt++;
        check("busy_with_done", 64'(busy0), 64'(0));
      end
      low_run = send0 ? 0 : low_run + 1;
      prev_send = send0;
      held = data0;
    end
  end

  // One burst on dut0; mode/continuous are scrambled and start re-pulsed
  // after LOAD to show they are ignored mid-burst.
  task automatic run_burst(input int m, input bit c, input int stop_at,
                           input int delay, output int cnt_out);
    int guard;
    words_q.delete();
    done_cnt = 0;
    first_word = 1'b1;
    resp_delay = delay;
    @(negedge clk);
    mode0 = 2'(m);
    cont0 = c;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("lat_load_sta", 64'(sta0), 64'(1));
    check("lat_load_send", 64'(send0), 64'(0));
    @(negedge clk);
    check("lat_send", 64'(send0), 64'(1));
    mode0 = 2'(m) ^ 2'b11;
    cont0 = ~c;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    if (stop_at > 0) begin
      guard = 0;
      while (words_q.size() < stop_at && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      stop0 = 1'b1;
      @(negedge clk);
      stop0 = 1'b0;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("done_timeout", 64'(1), 64'(0));
    repeat (GAP0 + 10) @(negedge clk);
    cnt_out = int'(wc0);
    check("idle_sta", 64'(sta0), 64'(0));
    check("idle_busy", 64'(busy0), 64'(0));
  endtask

  task automatic check_words(input int m, input int exp_n);
    check("nwords", 64'(words_q.size()), 64'(exp_n));
    for (int j = 0; j < words_q.size(); j++)
      check("model_word", 64'(words_q[j]), 64'(model_word(m, j % int'(N0))));
  endtask

  typedef struct {
    int          mode;
    bit          cont;
    int          stop_at;
    int          delay;
    int          exp_words;
    int          exp_cnt;
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[8];

  initial begin : main
    int cnt, n, guard, m, sa, dl;
    bit c;

    vecs[0] = '{0, 1'b0, 0,  3, 8,  8, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF};
    vecs[1] = '{1, 1'b0, 0,  2, 8,  8, 32'h0000FFFF, 32'h00010000, 32'h00010006};
    vecs[2] = '{2, 1'b0, 2,  2, 2,  2, 32'h0000FFFF, 32'h80207FFC, 32'h80207FFC};
    vecs[3] = '{3, 1'b0, 0,  1, 8,  8, 32'h00000001, 32'h00000002, 32'h00000080};
    vecs[4] = '{1, 1'b1, 10, 3, 10, 2, 32'h0000FFFF, 32'h00010000, 32'h00010000};
    vecs[5] = '{0, 1'b0, 3,  4, 3,  3, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF};
    vecs[6] = '{3, 1'b1, 9,  2, 9,  1, 32'h00000001, 32'h00000002, 32'h00000001};
    vecs[7] = '{2, 1'b0, 1,  1, 1,  1, 32'h0000FFFF, 32'h00000000, 32'h0000FFFF};

    rst = 1'b0;
    start0 = 0; stop0 = 0; cont0 = 0; mode0 = 0;
    start1 = 0; stop1 = 0; cont1 = 0; mode1 = 2'd1; sd1 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_send", 64'(send0), 64'(0));
    check("rst_busy", 64'(busy0), 64'(0));
    check("rst_done", 64'(done0), 64'(0));
    check("rst_data", 64'(data0), 64'(0));
    check("rst_wc", 64'(wc0), 64'(0));
    check("rst_sta", 64'(sta0), 64'(0));
    check("rst_send1", 64'(send1), 64'(0));
`ifdef UART_PATGEN_TIMEOUT_EN
    check("rst_err", 64'(err0), 64'(0));
`endif
    rst = 1'b1;

    // stop while idle must not shorten the next burst (row 0 has no stop)
    @(negedge clk);
    stop0 = 1'b1;
    @(negedge clk);
    stop0 = 1'b0;

    for (int r = 0; r < 8; r++) begin
      run_burst(vecs[r].mode, vecs[r].cont, vecs[r].stop_at, vecs[r].delay, cnt);
      check("tbl_cnt", 64'(cnt), 64'(vecs[r].exp_cnt));
      check("tbl_done_cnt", 64'(done_cnt), 64'(1));
      check_words(vecs[r].mode, vecs[r].exp_words);
      if (words_q.size() > 0) begin
        check("tbl_w0", 64'(words_q[0]), 64'(vecs[r].exp_w0));
        check("tbl_last", 64'(words_q[words_q.size()-1]), 64'(vecs[r].exp_last));
      end
      if (words_q.size() > 1 && vecs[r].exp_words >= 2)
        check("tbl_w1", 64'(words_q[1]), 64'(vecs[r].exp_w1));
    end

    // randomized bursts against the model
    for (int r = 0; r < 6; r++) begin
      m  = int'($urandom_range(0, 3));
      c  = 1'($urandom_range(0, 1));
      dl = int'($urandom_range(1, 5));
      if (c) sa = int'($urandom_range(1, 2 * N0 + 3));
      else   sa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, N0)) : 0;
      run_burst(m, c, sa, dl, cnt);
      check("rnd_cnt", 64'(cnt), 64'(model_cnt(model_nwords(sa))));
      check("rnd_done_cnt", 64'(done_cnt), 64'(1));
      check_words(m, model_nwords(sa));
    end

    // zero gap, send_done held high: send alternates, one low cycle per word
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("z_load_sta", 64'(sta1), 64'(1));
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      start1 = (k == 1);
      check("z_send", 64'(send1), 64'((k < 8) ? ((k % 2) == 0) : 0));
      if (k < 8 && (k % 2) == 0) check("z_data", 64'(data1), 64'(TB_SEED + 32'(k / 2)));
      if (k == 1) check("z_gap_sta", 64'(sta1), 64'(3));
      check("z_done", 64'(done1), 64'(k == 8));
    end
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (send1) n++;
    end
    check("z_no_restart", 64'(n), 64'(0));
    check("z_wc", 64'(wc1), 64'(N1));

    // asynchronous reset in the middle of word 3
    words_q.delete();
    first_word = 1'b1;
    resp_delay = 2;
    @(negedge clk);
    mode0 = 2'd1; cont0 = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    guard = 0;
    while (words_q.size() < 3 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    resp_delay = 30;
    repeat (3) @(negedge clk);
    check("pre_rst_send", 64'(send0), 64'(1));
    check("pre_rst_wc", 64'(wc0), 64'(2));
    #2 rst = 1'b0;
    #1;
    check("arst_send", 64'(send0), 64'(0));
    check("arst_busy", 64'(busy0), 64'(0));
    check("arst_data", 64'(data0), 64'(0));
    check("arst_wc", 64'(wc0), 64'(0));
    check("arst_sta", 64'(sta0), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    resp_delay = 2;

`ifdef UART_PATGEN_TIMEOUT_EN
    // no send_done: SEND lasts exactly 50 cycles, then err and done
    resp_delay = 1000;
    first_word = 1'b1;
    done_cnt = 0;
    @(negedge clk);
    mode0 = 2'd0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    n = 0;
    while (send0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("to_len", 64'(n), 64'(50));
    check("to_err", 64'(err0), 64'(1));
    check("to_done", 64'(done0), 64'(1));
    check("to_busy", 64'(busy0), 64'(0));
    run_burst(1, 1'b0, 0, 2, cnt);
    check("to_err_clr", 64'(err0), 64'(0));
    check_words(1, int'(N0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
